// File: rtl/pkt_rd_ctrl.sv
// ----------------------------------------------------------------------------
// pkt_rd_ctrl
//
// Avalon-MM read master that fetches one captured packet from memory, from
// the word-aligned begin address up to (not including) the end address, and
// pushes it word by word into the packet FIFO. Once the first burst has
// landed it kicks the downstream writer (wr_ctrl_o), then holds off the next
// packet until the writer reports the packet written. Bursts are only issued
// when the FIFO fill level leaves room for the whole burst plus a 2-word
// margin, so the FIFO cannot overflow.
//
// Optional feature (compile-time macro): PKT_RD_CTRL_BYTESWAP_EN
//   defined   : each 32-bit word is byte-reversed on its way into the FIFO
//               (network order -> host order).
//   undefined : words pass through unchanged. Timing is identical.
//
// Ports
//   clk              clock
//   reset            synchronous, active-low reset
//   start_i          one-cycle fetch request, honoured only in IDLE
//   pkt_begin_i      packet start byte address (bits [1:0] ignored)
//   pkt_end_i        packet end byte address, exclusive
//   usedw_i          FIFO fill level
//   fifo_data_o      FIFO write data (registered)
//   fifo_wr_o        FIFO write strobe (registered)
//   wr_ctrl_o        one-cycle start pulse to the downstream writer
//   wr_ctrl_rdy_i    one-cycle "packet written" pulse from the writer
//   busy_o           high outside IDLE
//   done_o           one-cycle completion pulse
//   address_o        Avalon read byte address, word aligned
//   read_o           Avalon read request
//   burstcount_o     Avalon burst length in words
//   waitrequest_i    Avalon stall
//   readdata_i       Avalon read data
//   readdatavalid_i  Avalon read data valid
// ----------------------------------------------------------------------------
module pkt_rd_ctrl #(
    parameter int unsigned BURST_SIZE_WORDS = 4,
    parameter int unsigned FIFO_DEPTH       = 512
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start_i,
    input  logic [31:0]                   pkt_begin_i,
    input  logic [31:0]                   pkt_end_i,
    input  logic [$clog2(FIFO_DEPTH)-1:0] usedw_i,
    output logic [31:0]                   fifo_data_o,
    output logic                          fifo_wr_o,
    output logic                          wr_ctrl_o,
    input  logic                          wr_ctrl_rdy_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [31:0]                   address_o,
    output logic                          read_o,
    output logic [15:0]                   burstcount_o,
    input  logic                          waitrequest_i,
    input  logic [31:0]                   readdata_i,
    input  logic                          readdatavalid_i
);

    localparam logic [15:0] BURST_W   = 16'(BURST_SIZE_WORDS);
    localparam logic [31:0] SPACE_LIM = 32'(FIFO_DEPTH - 2);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        WAIT_SPACE,
        REQ,
        DATA,
        WAIT_WR,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;          // next burst address
    logic [31:0] end_q, end_d;            // packet end address
    logic [15:0] remaining_q, remaining_d;
    logic [15:0] burst_q, burst_d;        // length of the burst in flight
    logic [15:0] beat_cnt_q, beat_cnt_d;
    logic        first_q, first_d;        // first burst of the packet not yet done
    logic        fifo_wr_q, fifo_wr_d;
    logic [31:0] fifo_data_q, fifo_data_d;
    logic        wr_ctrl_q, wr_ctrl_d;

    logic [31:0] len;
    logic [15:0] total_words;
    logic [15:0] burst_len;
    logic        space_ok;
    logic        rd_beat;
    logic        beat_last;
    logic [31:0] beat_data;

`ifdef PKT_RD_CTRL_BYTESWAP_EN
    assign beat_data = {readdata_i[7:0], readdata_i[15:8],
                        readdata_i[23:16], readdata_i[31:24]};
`else
    assign beat_data = readdata_i;
`endif

    // Word count rounds a trailing partial word up.
    assign len         = end_q - addr_q;
    assign total_words = {2'b00, len[15:2]} + {15'd0, |len[1:0]};

    assign burst_len = (remaining_q < BURST_W) ? remaining_q : BURST_W;

    // The 2-word margin absorbs the lag of usedw behind our own writes.
    assign space_ok = (32'(usedw_i) + 32'(burst_len)) <= SPACE_LIM;

    // Beats are only taken in DATA; anything else (stale beats of an aborted
    // burst, stray valids) is dropped.
    assign rd_beat   = readdatavalid_i && (state_q == DATA);
    assign beat_last = rd_beat && ((beat_cnt_q + 16'd1) == burst_q);

    // NOTE: every signal driven here gets its default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        end_d       = end_q;
        remaining_d = remaining_q;
        burst_d     = burst_q;
        beat_cnt_d  = beat_cnt_q;
        first_d     = first_q;
        fifo_wr_d   = 1'b0;
        fifo_data_d = fifo_data_q;
        wr_ctrl_d   = 1'b0;

        if (rd_beat) begin
            fifo_wr_d   = 1'b1;
            fifo_data_d = beat_data;
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    addr_d  = {pkt_begin_i[31:2], 2'b00};
                    end_d   = pkt_end_i;
                    state_d = LATCH;
                end
            end

            LATCH: begin
                remaining_d = total_words;
                first_d     = 1'b1;
                state_d     = (end_q <= addr_q) ? DONE : WAIT_SPACE;
            end

            WAIT_SPACE: begin
                if (space_ok) begin
                    burst_d    = burst_len;
                    beat_cnt_d = 16'd0;
                    state_d    = REQ;
                end
            end

            REQ: begin
                // read_o is high throughout REQ, so !waitrequest is the accept.
                if (!waitrequest_i) begin
                    state_d = DATA;
                end
            end

            DATA: begin
                if (rd_beat) begin
                    beat_cnt_d = beat_cnt_q + 16'd1;
                end
                if (beat_last) begin
                    addr_d      = addr_q + {14'd0, burst_q, 2'b00};
                    remaining_d = remaining_q - burst_q;
                    wr_ctrl_d   = first_q;
                    first_d     = 1'b0;
                    state_d     = (remaining_q != burst_q) ? WAIT_SPACE : WAIT_WR;
                end
            end

            WAIT_WR: begin
                if (wr_ctrl_rdy_i) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            end_q       <= '0;
            remaining_q <= '0;
            burst_q     <= '0;
            beat_cnt_q  <= '0;
            first_q     <= 1'b0;
            fifo_wr_q   <= 1'b0;
            fifo_data_q <= '0;
            wr_ctrl_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            end_q       <= end_d;
            remaining_q <= remaining_d;
            burst_q     <= burst_d;
            beat_cnt_q  <= beat_cnt_d;
            first_q     <= first_d;
            fifo_wr_q   <= fifo_wr_d;
            fifo_data_q <= fifo_data_d;
            wr_ctrl_q   <= wr_ctrl_d;
        end
    end

    // All outputs come straight from registers or from the state register.
    assign read_o       = (state_q == REQ);
    assign address_o    = addr_q;
    assign burstcount_o = burst_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);
    assign fifo_wr_o    = fifo_wr_q;
    assign fifo_data_o  = fifo_data_q;
    assign wr_ctrl_o    = wr_ctrl_q;

endmodule

// File: tb/tb_pkt_rd_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pkt_rd_ctrl
//
// Self-checking bench for pkt_rd_ctrl. A behavioural Avalon slave answers
// bursts from a synthetic memory with random stalls and beat gaps; a monitor
// logs FIFO writes, bursts and pulses; each scenario task compares the logs
// against the packet-level expectation (burst list and word list computed
// from the begin/end addresses).
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pkt_rd_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_i;
    logic [31:0] pkt_begin_i;
    logic [31:0] pkt_end_i;
    logic [8:0]  usedw_i;
    logic [31:0] fifo_data_o;
    logic        fifo_wr_o;
    logic        wr_ctrl_o;
    logic        wr_ctrl_rdy_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] address_o;
    logic        read_o;
    logic [15:0] burstcount_o;
    logic        waitrequest_i;
    logic [31:0] readdata_i;
    logic        readdatavalid_i;

    pkt_rd_ctrl #(
        .BURST_SIZE_WORDS(4),
        .FIFO_DEPTH      (512)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start_i),
        .pkt_begin_i    (pkt_begin_i),
        .pkt_end_i      (pkt_end_i),
        .usedw_i        (usedw_i),
        .fifo_data_o    (fifo_data_o),
        .fifo_wr_o      (fifo_wr_o),
        .wr_ctrl_o      (wr_ctrl_o),
        .wr_ctrl_rdy_i  (wr_ctrl_rdy_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .address_o      (address_o),
        .read_o         (read_o),
        .burstcount_o   (burstcount_o),
        .waitrequest_i  (waitrequest_i),
        .readdata_i     (readdata_i),
        .readdatavalid_i(readdatavalid_i)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          len;
    } burst_t;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Observed activity
    burst_t      burst_log[$];
    logic [31:0] fifo_log[$];
    int          fifo_cyc[$];
    int          read_rise[$];
    int          read_cycles = 0;
    int          wr_cnt      = 0;
    int          wr_cyc      = -1;
    int          done_cnt    = 0;
    int          done_cyc    = -1;
    int          stab_err    = 0;
    logic        read_prev   = 1'b0;

    // Slave behaviour knobs
    int          ws_fixed = -1;   // -1: random 0..2 stall cycles per request
    int          gap_min  = 0;
    int          gap_max  = 2;
    bit          spur_req = 1'b0;
    logic [31:0] beat_q[$];

    // Expectations
    burst_t      exp_bursts[$];
    logic [31:0] exp_words[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a);
`ifdef PKT_RD_CTRL_BYTESWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Avalon slave: drives its inputs 1 ns after each rising edge.
    initial begin : slave
        bit          accept_pend = 1'b0;
        bit          in_req      = 1'b0;
        bit          prev_stall  = 1'b0;
        int          ws_target   = 0;
        int          ws_cnt      = 0;
        int          gap_cnt     = 0;
        logic [31:0] acc_addr    = '0;
        logic [31:0] prev_addr   = '0;
        logic [15:0] acc_bc      = '0;
        logic [15:0] prev_bc     = '0;
        burst_t      bt;
        waitrequest_i   = 1'b0;
        readdatavalid_i = 1'b0;
        readdata_i      = '0;
        forever begin
            @(posedge clk);
            #1;
            if (prev_stall) begin
                if (read_o !== 1'b1 || address_o !== prev_addr || burstcount_o !== prev_bc)
                    stab_err++;
            end
            if (accept_pend) begin
                bt.addr = acc_addr;
                bt.len  = int'(acc_bc);
                burst_log.push_back(bt);
                for (int k = 0; k < int'(acc_bc); k++)
                    beat_q.push_back(acc_addr + 32'(4 * k));
            end
            readdatavalid_i = 1'b0;
            if (spur_req) begin
                readdatavalid_i = 1'b1;
                readdata_i      = 32'hDEAD_BEEF;
                spur_req        = 1'b0;
            end else if (beat_q.size() > 0) begin
                if (gap_cnt > 0) begin
                    gap_cnt--;
                end else begin
                    readdatavalid_i = 1'b1;
                    readdata_i      = mem_word(beat_q.pop_front());
                    gap_cnt         = int'($urandom_range(32'(gap_max), 32'(gap_min)));
                end
            end else begin
                gap_cnt = 0;
            end
            if (read_o === 1'b1) begin
                if (!in_req) begin
                    in_req    = 1'b1;
                    ws_cnt    = 0;
                    ws_target = (ws_fixed >= 0) ? ws_fixed : int'($urandom_range(2, 0));
                end
                waitrequest_i = (ws_cnt < ws_target);
                if (waitrequest_i) ws_cnt++;
            end else begin
                in_req        = 1'b0;
                waitrequest_i = 1'b0;
            end
            accept_pend = (read_o === 1'b1) && !waitrequest_i;
            if (accept_pend) begin
                acc_addr = address_o;
                acc_bc   = burstcount_o;
                in_req   = 1'b0;
            end
            prev_stall = (read_o === 1'b1) && waitrequest_i;
            prev_addr  = address_o;
            prev_bc    = burstcount_o;
        end
    end

    // Monitor samples on the falling edge, well away from the active edge.
    initial forever begin
        @(negedge clk);
        if (fifo_wr_o === 1'b1) begin
            fifo_log.push_back(fifo_data_o);
            fifo_cyc.push_back(cyc);
        end
        if (wr_ctrl_o === 1'b1) begin
            wr_cnt++;
            wr_cyc = cyc;
        end
        if (done_o === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (read_o === 1'b1) begin
            read_cycles++;
            if (read_prev !== 1'b1) read_rise.push_back(cyc);
        end
        read_prev = read_o;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        burst_log.delete();
        fifo_log.delete();
        fifo_cyc.delete();
        read_rise.delete();
        read_cycles = 0;
        wr_cnt      = 0;
        wr_cyc      = -1;
        done_cnt    = 0;
        done_cyc    = -1;
        stab_err    = 0;
    endtask

    // Packet-level reference: word count from the byte span, split into
    // bursts of at most 4 words.
    task automatic build_expected(input logic [31:0] b, input logic [31:0] e);
        logic [31:0] lo;
        logic [31:0] a;
        int          rem;
        int          n;
        burst_t      bt;
        exp_bursts.delete();
        exp_words.delete();
        lo = b & ~32'd3;
        if (e > lo) begin
            rem = int'((e - lo + 32'd3) / 32'd4);
            a   = lo;
            while (rem > 0) begin
                n       = (rem < 4) ? rem : 4;
                bt.addr = a;
                bt.len  = n;
                exp_bursts.push_back(bt);
                for (int k = 0; k < n; k++) exp_words.push_back(exp_data(a + 32'(4 * k)));
                a   = a + 32'(4 * n);
                rem = rem - n;
            end
        end
    endtask

    // Fetch one packet and score it. hold > 0: usedw_i starts high and is
    // dropped to 506 after hold cycles. early: inject an ignored start and
    // wr_ctrl_rdy in the middle of the first burst.
    task automatic run_packet(input logic [31:0] b, input logic [31:0] e,
                              input bit early, input int hold, input string name);
        int s;
        int rdy_cyc;
        int t;
        int idx;
        bit zero;
        clear_logs();
        build_expected(b, e);
        zero        = (exp_bursts.size() == 0);
        s           = cyc;
        start_i     = 1'b1;
        pkt_begin_i = b;
        pkt_end_i   = e;
        step();
        start_i     = 1'b0;
        pkt_begin_i = $urandom;
        pkt_end_i   = $urandom;

        if (zero) begin
            t = 0;
            while (done_cnt == 0 && t < 20) begin step(); t++; end
            n_checks++;
            if (done_cnt !== 1 || done_cyc !== s + 2) begin
                n_fail++;
                $display("FAIL %s zero-length done: got %0d pulses at cycle %0d, expected 1 at cycle %0d",
                         name, done_cnt, done_cyc, s + 2);
            end
            n_checks++;
            if (read_cycles !== 0 || wr_cnt !== 0) begin
                n_fail++;
                $display("FAIL %s zero-length activity: got %0d read cycles, %0d wr_ctrl, expected 0 and 0",
                         name, read_cycles, wr_cnt);
            end
        end else begin
            if (hold > 0) begin
                repeat (hold) step();
                n_checks++;
                if (read_cycles !== 0) begin
                    n_fail++;
                    $display("FAIL %s read while FIFO full: got %0d read cycles, expected 0", name, read_cycles);
                end
                usedw_i = 9'd506;
            end
            if (early) begin
                t = 0;
                while (fifo_log.size() < 1 && t < 200) begin step(); t++; end
                start_i       = 1'b1;
                pkt_begin_i   = 32'h0000_F000;
                pkt_end_i     = 32'h0000_F100;
                wr_ctrl_rdy_i = 1'b1;
                step();
                start_i       = 1'b0;
                wr_ctrl_rdy_i = 1'b0;
            end
            t = 0;
            while (fifo_log.size() < exp_words.size() && t < 2000) begin step(); t++; end
            repeat (3) step();
            n_checks++;
            if (done_cnt !== 0) begin
                n_fail++;
                $display("FAIL %s done before wr_ctrl_rdy: got %0d, expected 0", name, done_cnt);
            end
            rdy_cyc       = cyc;
            wr_ctrl_rdy_i = 1'b1;
            step();
            wr_ctrl_rdy_i = 1'b0;
            t = 0;
            while (done_cnt == 0 && t < 20) begin step(); t++; end
            n_checks++;
            if (done_cnt !== 1 || done_cyc !== rdy_cyc + 1) begin
                n_fail++;
                $display("FAIL %s done timing: got %0d pulses at cycle %0d, expected 1 at cycle %0d",
                         name, done_cnt, done_cyc, rdy_cyc + 1);
            end
            n_checks++;
            if (wr_cnt !== 1) begin
                n_fail++;
                $display("FAIL %s wr_ctrl count: got %0d, expected 1", name, wr_cnt);
            end
            idx = exp_bursts[0].len - 1;
            n_checks++;
            if (fifo_cyc.size() <= idx) begin
                n_fail++;
                $display("FAIL %s wr_ctrl timing: first burst incomplete, got %0d writes", name, fifo_cyc.size());
            end else if (wr_cyc !== fifo_cyc[idx]) begin
                n_fail++;
                $display("FAIL %s wr_ctrl timing: got cycle %0d, expected %0d", name, wr_cyc, fifo_cyc[idx]);
            end
            if (hold == 0) begin
                n_checks++;
                if (read_rise.size() == 0 || read_rise[0] !== s + 3) begin
                    n_fail++;
                    $display("FAIL %s start-to-read latency: got cycle %0d, expected %0d",
                             name, (read_rise.size() == 0) ? -1 : read_rise[0], s + 3);
                end
            end
            idx = -1;
            for (int i = 1; i < exp_bursts.size(); i++) begin
                idx = idx + exp_bursts[i-1].len;
                n_checks++;
                if (read_rise.size() <= i || fifo_cyc.size() <= idx) begin
                    n_fail++;
                    $display("FAIL %s burst %0d gap: missing read or beats", name, i);
                end else if (read_rise[i] < fifo_cyc[idx] + 1) begin
                    n_fail++;
                    $display("FAIL %s burst %0d gap: read at %0d, expected >= %0d",
                             name, i, read_rise[i], fifo_cyc[idx] + 1);
                end
            end
        end

        n_checks++;
        if (burst_log.size() !== exp_bursts.size()) begin
            n_fail++;
            $display("FAIL %s burst count: got %0d, expected %0d", name, burst_log.size(), exp_bursts.size());
        end
        for (int i = 0; i < exp_bursts.size() && i < burst_log.size(); i++) begin
            n_checks++;
            if (burst_log[i].addr !== exp_bursts[i].addr || burst_log[i].len !== exp_bursts[i].len) begin
                n_fail++;
                $display("FAIL %s burst %0d: got addr %08h len %0d, expected addr %08h len %0d", name, i,
                         burst_log[i].addr, burst_log[i].len, exp_bursts[i].addr, exp_bursts[i].len);
            end
        end
        n_checks++;
        if (fifo_log.size() !== exp_words.size()) begin
            n_fail++;
            $display("FAIL %s fifo_wr count: got %0d, expected %0d", name, fifo_log.size(), exp_words.size());
        end
        for (int k = 0; k < exp_words.size() && k < fifo_log.size(); k++) begin
            n_checks++;
            if (fifo_log[k] !== exp_words[k]) begin
                n_fail++;
                $display("FAIL %s fifo_data[%0d]: got %08h, expected %08h", name, k, fifo_log[k], exp_words[k]);
            end
        end
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        start_i       = 1'b0;
        pkt_begin_i   = '0;
        pkt_end_i     = '0;
        usedw_i       = '0;
        wr_ctrl_rdy_i = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({fifo_wr_o, wr_ctrl_o, busy_o, done_o, read_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset strobes: got fifo_wr/wr_ctrl/busy/done/read=%05b, expected 00000",
                     {fifo_wr_o, wr_ctrl_o, busy_o, done_o, read_o});
        end
        n_checks++;
        if (fifo_data_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset fifo_data: got %08h, expected 00000000", fifo_data_o);
        end
        n_checks++;
        if (address_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset address: got %08h, expected 00000000", address_o);
        end
        n_checks++;
        if (burstcount_o !== 16'd0) begin
            n_fail++;
            $display("FAIL reset burstcount: got %0d, expected 0", burstcount_o);
        end
        reset = 1'b1;
        step();
        clear_logs();
        spur_req = 1'b1;
        repeat (4) step();
        n_checks++;
        if (fifo_log.size() !== 0) begin
            n_fail++;
            $display("FAIL idle readdatavalid: got %0d fifo writes, expected 0", fifo_log.size());
        end
    endtask

    task automatic test_aligned();
        run_packet(32'h0000_1000, 32'h0000_1040, 1'b0, 0, "aligned");
    endtask

    task automatic test_odd_length();
        run_packet(32'h0000_2000, 32'h0000_2016, 1'b0, 0, "odd_length");
    endtask

    task automatic test_backpressure();
        ws_fixed = 5;
        run_packet(32'h0000_6000, 32'h0000_6030, 1'b0, 0, "backpressure");
        n_checks++;
        if (stab_err !== 0) begin
            n_fail++;
            $display("FAIL backpressure stability: got %0d unstable stall cycles, expected 0", stab_err);
        end
        n_checks++;
        if (read_cycles !== 6 * 3) begin
            n_fail++;
            $display("FAIL backpressure read cycles: got %0d, expected %0d", read_cycles, 6 * 3);
        end
        ws_fixed = -1;
    endtask

    task automatic test_fifo_full();
        usedw_i = 9'd508;
        run_packet(32'h0000_4000, 32'h0000_4020, 1'b0, 30, "fifo_full");
        usedw_i = 9'd0;
    endtask

    task automatic test_zero_length();
        run_packet(32'h0000_3000, 32'h0000_3000, 1'b0, 0, "zero_length");
    endtask

    task automatic test_ignored_inputs();
        run_packet(32'h0000_7000, 32'h0000_7040, 1'b1, 0, "ignored_inputs");
    endtask

    task automatic test_reset_abort();
        int t;
        clear_logs();
        gap_min     = 3;
        gap_max     = 3;
        ws_fixed    = 0;
        start_i     = 1'b1;
        pkt_begin_i = 32'h0000_5000;
        pkt_end_i   = 32'h0000_5010;
        step();
        start_i = 1'b0;
        t = 0;
        while (fifo_log.size() < 2 && t < 200) begin step(); t++; end
        reset = 1'b0;
        step();
        reset = 1'b1;
        n_checks++;
        if (read_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort read: got %b, expected 0", read_o);
        end
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort busy: got %b, expected 0", busy_o);
        end
        repeat (20) step();
        n_checks++;
        if (fifo_log.size() !== 2) begin
            n_fail++;
            $display("FAIL abort late beats: got %0d fifo writes, expected 2", fifo_log.size());
        end
        n_checks++;
        if (wr_cnt !== 0) begin
            n_fail++;
            $display("FAIL abort wr_ctrl: got %0d pulses, expected 0", wr_cnt);
        end
        gap_min  = 0;
        gap_max  = 2;
        ws_fixed = -1;
    endtask

    task automatic test_random_back_to_back();
        logic [31:0] b;
        logic [31:0] e;
        for (int i = 0; i < 10; i++) begin
            b = 32'h0000_8000 + 32'($urandom_range(255, 0));
            if ($urandom_range(5, 0) == 0)
                e = b - 32'($urandom_range(8, 1));
            else
                e = b + 32'($urandom_range(40, 0));
            run_packet(b, e, 1'b0, 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_odd_length();
        test_backpressure();
        test_fifo_full();
        test_zero_length();
        test_ignored_inputs();
        test_reset_abort();
        test_random_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
